// File: rtl/grand_adder_pipe.sv
// Two-stage pipelined MAC final adder: merges the Wallace sum/carry with the aligned
// high part of A and selects the positive magnitude, sign, sign-flip and minus-sticky.
module grand_adder_pipe #(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [2*PARM_MANT+1:0]   CSA_sum_i,
    input  logic [2*PARM_MANT+1:0]   CSA_carry_i,
    input  logic                     Sub_Sign_i,
    input  logic                     Wallace_supp_ext_i,
    input  logic [1:0]               Wallace_carry_2msb_i,
    input  logic                     Wallace_sum_msb_i,
    input  logic                     Exp_mv_sign_i,
    input  logic                     Mv_halt_i,
    input  logic                     Sign_aligned_i,
    input  logic [PARM_MANT+3:0]     A_Mant_aligned_high_i,
    input  logic                     BC_special_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [3*PARM_MANT+4:0]   PosSum_o,
    output logic                     Adder_sign_o,
    output logic                     Sign_flip_o,
    output logic                     Minus_sticky_bit_o
);

    localparam int M  = PARM_MANT;
    localparam int LW = 2*M + 2;
    localparam int HW = M + 4;
    localparam int RW = 3*M + 5;

    // The exponent width only sizes the exp-move operand, which this block never sees.
    if (PARM_EXP < 1) begin : g_bad_exp
        $error("PARM_EXP must be positive");
    end

    function automatic logic [LW:0] low_sum(input logic [LW-1:0] s, input logic [LW:0] y);
        return {1'b0, s} + y;
    endfunction

    function automatic logic [LW:0] low_sum_inv(input logic [LW-1:0] s, input logic [LW:0] y);
        return (LW+1)'(2) + {1'b1, ~s} + ~y;
    endfunction

    logic vld_p1, vld_p2;
    logic s2_ready, accept, adv;

    assign s2_ready   = ~vld_p2 | out_ready_i;
    assign in_ready_o = ~vld_p1 | s2_ready;
    assign accept     = in_valid_i & in_ready_o & ~flush_i;
    assign adv        = vld_p1 & s2_ready & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (accept)
                vld_p1 <= 1'b1;
            else if (s2_ready)
                vld_p1 <= 1'b0;
            if (s2_ready)
                vld_p2 <= vld_p1;
        end
    end

    // ---- Stage 1: low-part sum and its two's-complement counterpart ----
    logic          corr, cp;
    logic [LW:0]   y_op, lsum, lsum_inv;

    always_comb begin
        corr     = Wallace_supp_ext_i | Wallace_carry_2msb_i[1]
                 | (Wallace_sum_msb_i & Wallace_carry_2msb_i[0]);
        cp       = Exp_mv_sign_i ? 1'b0 : (~corr ^ CSA_carry_i[LW-1]);
        y_op     = {cp, CSA_carry_i[LW-2:0], Sub_Sign_i};
        lsum     = low_sum(CSA_sum_i, y_op);
        lsum_inv = low_sum_inv(CSA_sum_i, y_op);
    end

    logic [LW-1:0] ls_p1, lsi_p1;
    logic          lc_p1, lci_p1;
    logic [HW-1:0] a_p1;
    logic          sub_p1, exp_p1, halt_p1, sgn_p1, bc_p1;

    always_ff @(posedge clk_i) begin
        if (accept) begin
            ls_p1   <= lsum[LW-1:0];
            lc_p1   <= lsum[LW];
            lsi_p1  <= lsum_inv[LW-1:0];
            lci_p1  <= lsum_inv[LW];
            a_p1    <= A_Mant_aligned_high_i;
            sub_p1  <= Sub_Sign_i;
            exp_p1  <= Exp_mv_sign_i;
            halt_p1 <= Mv_halt_i;
            sgn_p1  <= Sign_aligned_i;
            bc_p1   <= BC_special_i;
        end
    end

    // ---- Stage 2: high-part increment/complement and result select ----
    logic [HW-1:0] hs, sub_res;
    logic [HW-2:0] hsi;
    logic          flip, sign_d, sticky_d;
    logic [RW-1:0] pos_d;

    always_comb begin
        hs       = a_p1 + HW'(lc_p1);
        hsi      = lci_p1 ? ~a_p1[HW-2:0] : (~a_p1[HW-2:0] - (HW-1)'(1));
        flip     = hs[HW-1];
        sub_res  = {a_p1[HW-2:0], 1'b0} - {{(HW-1){1'b0}}, ~bc_p1};
        sign_d   = exp_p1 ? sgn_p1 : (flip ^ sgn_p1);
        sticky_d = exp_p1 & ~bc_p1;
        if (halt_p1)
            pos_d = {{(M+3){1'b0}}, ls_p1};
        else if (exp_p1 && sub_p1)
            pos_d = {sub_res, {(2*M+1){1'b0}}};
        else if (exp_p1)
            pos_d = {a_p1[HW-2:0], {LW{1'b0}}};
        else if (flip)
            pos_d = {hsi, lsi_p1};
        else
            pos_d = {hs[HW-2:0], ls_p1};
    end

    logic [RW-1:0] pos_p2;
    logic          sign_p2, flip_p2, sticky_p2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_p2    <= '0;
            sign_p2   <= 1'b0;
            flip_p2   <= 1'b0;
            sticky_p2 <= 1'b0;
        end else if (adv) begin
            pos_p2    <= pos_d;
            sign_p2   <= sign_d;
            flip_p2   <= flip;
            sticky_p2 <= sticky_d;
        end
    end

    assign out_valid_o        = vld_p2;
    assign PosSum_o           = pos_p2;
    assign Adder_sign_o       = sign_p2;
    assign Sign_flip_o        = flip_p2;
    assign Minus_sticky_bit_o = sticky_p2;

endmodule

// File: tb/tb_grand_adder_pipe.sv
// Bench for grand_adder_pipe: directed scenarios plus randomized traffic against
// an arithmetic reference model and an in-order scoreboard.
module tb_grand_adder_pipe;

    localparam int M  = 23;
    localparam int LW = 2*M + 2;
    localparam int HW = M + 4;
    localparam int RW = 3*M + 5;

    typedef struct {
        logic [LW-1:0] sum;
        logic [LW-1:0] carry;
        logic          sub;
        logic          supp;
        logic [1:0]    c2;
        logic          smsb;
        logic          exp_mv;
        logic          halt;
        logic          sgn;
        logic [HW-1:0] a;
        logic          bc;
    } op_t;

    typedef struct {
        logic [RW-1:0] pos;
        logic          sign;
        logic          flip;
        logic          sticky;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [LW-1:0] sum, carry;
    logic          sub, supp, smsb, exp_mv, halt, sgn, bc;
    logic [1:0]    c2;
    logic [HW-1:0] a;
    logic [RW-1:0] pos_sum;
    logic          adder_sign, sign_flip, minus_sticky;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    grand_adder_pipe #(.PARM_EXP(8), .PARM_MANT(M)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .CSA_sum_i(sum), .CSA_carry_i(carry), .Sub_Sign_i(sub),
        .Wallace_supp_ext_i(supp), .Wallace_carry_2msb_i(c2), .Wallace_sum_msb_i(smsb),
        .Exp_mv_sign_i(exp_mv), .Mv_halt_i(halt), .Sign_aligned_i(sgn),
        .A_Mant_aligned_high_i(a), .BC_special_i(bc),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .PosSum_o(pos_sum), .Adder_sign_o(adder_sign), .Sign_flip_o(sign_flip),
        .Minus_sticky_bit_o(minus_sticky)
    );

    // Low sum is an ordinary add; the inverted path is its negation mod 2^(LW+1),
    // and the inverted high part is -A-2+lci mod 2^HW.
    function automatic res_t model(input op_t o);
        res_t r;
        logic [127:0] y, s, ng, hs, hsi, t, m_low, m_hi, m_a;
        logic corr, cp, lc, lci, flip;
        m_low = (128'd1 << (LW+1)) - 128'd1;
        m_hi  = (128'd1 << HW) - 128'd1;
        m_a   = (128'd1 << (HW-1)) - 128'd1;
        corr  = o.supp | o.c2[1] | (o.smsb & o.c2[0]);
        cp    = o.exp_mv ? 1'b0 : (~corr ^ o.carry[LW-1]);
        y     = ({127'd0, cp} << LW)
              + (({80'd0, o.carry} & ((128'd1 << (LW-1)) - 128'd1)) * 2)
              + {127'd0, o.sub};
        s     = ({80'd0, o.sum} + y) & m_low;
        lc    = s[LW];
        ng    = (128'd0 - s) & m_low;
        lci   = ng[LW];
        hs    = ({101'd0, o.a} + {127'd0, lc}) & m_hi;
        hsi   = (128'd0 - {101'd0, o.a} - 128'd2 + {127'd0, lci}) & m_hi;
        flip  = hs[HW-1];
        if (o.halt)
            t = s & ((128'd1 << LW) - 128'd1);
        else if (o.exp_mv && o.sub)
            t = (((({101'd0, o.a} & m_a) * 2) - (o.bc ? 128'd0 : 128'd1)) & m_hi) << (2*M+1);
        else if (o.exp_mv)
            t = ({101'd0, o.a} & m_a) << LW;
        else if (flip)
            t = ((hsi & m_a) << LW) | (ng & ((128'd1 << LW) - 128'd1));
        else
            t = ((hs & m_a) << LW) | (s & ((128'd1 << LW) - 128'd1));
        r.pos    = t[RW-1:0];
        r.sign   = o.exp_mv ? o.sgn : (flip ^ o.sgn);
        r.flip   = flip;
        r.sticky = o.exp_mv & ~o.bc;
        return r;
    endfunction

    function automatic op_t zero_op();
        op_t o;
        o.sum = '0; o.carry = '0; o.sub = 0; o.supp = 0; o.c2 = '0; o.smsb = 0;
        o.exp_mv = 0; o.halt = 0; o.sgn = 0; o.a = '0; o.bc = 0;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.sum    = LW'({$urandom(), $urandom()});
        o.carry  = LW'({$urandom(), $urandom()});
        o.sub    = 1'($urandom());
        o.supp   = 1'($urandom());
        o.c2     = 2'($urandom());
        o.smsb   = 1'($urandom());
        o.exp_mv = ($urandom_range(0, 5) == 0);
        o.halt   = ($urandom_range(0, 7) == 0);
        o.sgn    = 1'($urandom());
        o.a      = HW'($urandom());
        o.bc     = 1'($urandom());
        return o;
    endfunction

    task automatic drive(input op_t o);
        sum = o.sum; carry = o.carry; sub = o.sub; supp = o.supp; c2 = o.c2;
        smsb = o.smsb; exp_mv = o.exp_mv; halt = o.halt; sgn = o.sgn; a = o.a; bc = o.bc;
    endtask

    task automatic sample(output res_t r);
        r.pos = pos_sum; r.sign = adder_sign; r.flip = sign_flip; r.sticky = minus_sticky;
    endtask

    // Push one op through an empty pipe with out_ready held high and capture its result.
    task automatic run_single(input op_t o, output res_t got, output bit ok);
        ok = 0;
        got.pos = '0; got.sign = 0; got.flip = 0; got.sticky = 0;
        @(negedge clk);
        drive(o); in_valid = 1; out_ready = 1; flush = 0;
        #1;
        for (int i = 0; i < 10 && !in_ready; i++) begin
            @(negedge clk); #1;
        end
        @(negedge clk);
        in_valid = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid) begin
                sample(got);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
        drive(zero_op());
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (pos_sum !== '0) begin errors++; $display("FAIL reset_possum: got %h want 0", pos_sum); end
        checks++;
        if ({adder_sign, sign_flip, minus_sticky} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {adder_sign, sign_flip, minus_sticky});
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        op_t o; res_t got; bit ok;
        for (int s = 0; s < 2; s++) begin
            o = zero_op();
            o.sum = 5; o.carry = 3; o.supp = 1; o.sgn = s[0];
            run_single(o, got, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL add_timeout: got no out_valid want result"); end
            checks++;
            if (got.pos !== RW'(11)) begin errors++; $display("FAIL add_possum: got %h want %h", got.pos, RW'(11)); end
            checks++;
            if ({got.flip, got.sign} !== {1'b0, s[0]}) begin
                errors++; $display("FAIL add_sign: got flip=%b sign=%b want flip=0 sign=%b", got.flip, got.sign, s[0]);
            end
        end
    endtask

    task automatic test_exp_mv();
        op_t o; res_t got; bit ok;
        logic [RW-1:0] want_pos;
        logic          want_sticky;
        for (int c = 0; c < 3; c++) begin
            o = zero_op();
            o.exp_mv = 1; o.a = 1; o.sgn = 1'($urandom());
            o.sum = LW'({$urandom(), $urandom()}); o.carry = LW'({$urandom(), $urandom()});
            o.sub = (c != 0); o.bc = (c == 2);
            want_pos = (c == 0) ? RW'(1) : ((c == 1) ? RW'(1) : RW'(2));
            want_pos = want_pos << ((c == 0) ? 48 : 47);
            want_sticky = (c != 2);
            run_single(o, got, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL expmv_timeout case %0d: got no out_valid want result", c); end
            checks++;
            if (got.pos !== want_pos) begin
                errors++; $display("FAIL expmv_possum case %0d: got %h want %h", c, got.pos, want_pos);
            end
            checks++;
            if ({got.sticky, got.sign} !== {want_sticky, o.sgn}) begin
                errors++; $display("FAIL expmv_flags case %0d: got sticky=%b sign=%b want sticky=%b sign=%b",
                                   c, got.sticky, got.sign, want_sticky, o.sgn);
            end
        end
    endtask

    task automatic test_flip_halt();
        op_t o; res_t got; bit ok;
        logic [RW-1:0] want_pos;
        o = zero_op();
        o.sum = 5; o.carry = 3; o.supp = 1; o.a = '1; o.sgn = 1'($urandom());
        want_pos = (RW'(1) << 48) - RW'(11);
        run_single(o, got, ok);
        checks++;
        if (!ok || got.flip !== 1'b1) begin errors++; $display("FAIL flip_bit: got %b want 1", got.flip); end
        checks++;
        if (got.pos !== want_pos) begin errors++; $display("FAIL flip_possum: got %h want %h", got.pos, want_pos); end
        checks++;
        if (got.sign !== ~o.sgn) begin errors++; $display("FAIL flip_sign: got %b want %b", got.sign, ~o.sgn); end

        o = zero_op();
        o.halt = 1; o.sum = 7; o.supp = 1; o.a = HW'($urandom()); o.sgn = 1'($urandom());
        run_single(o, got, ok);
        checks++;
        if (!ok || got.pos !== RW'(7)) begin errors++; $display("FAIL halt_possum: got %h want %h", got.pos, RW'(7)); end
    endtask

    task automatic test_backpressure();
        op_t  ops[4];
        res_t exp_q[$];
        res_t got, e;
        int   idx, delivered;
        bit   gap_ok;
        for (int i = 0; i < 4; i++) ops[i] = rand_op();
        idx = 0;
        @(negedge clk);
        out_ready = 0; flush = 0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            drive(ops[idx]); in_valid = 1;
            #1;
            if (in_ready) begin exp_q.push_back(model(ops[idx])); idx++; end
        end
        checks++;
        if (idx != 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", idx); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
        delivered = 0; gap_ok = 1;
        for (int c = 0; c < 12 && delivered < 4; c++) begin
            @(negedge clk);
            out_ready = 1;
            if (idx < 4) begin drive(ops[idx]); in_valid = 1; end
            else in_valid = 0;
            #1;
            if (out_valid) begin
                sample(got);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra_output: got %h want nothing", got.pos);
                end else begin
                    e = exp_q.pop_front();
                    if ({got.pos, got.sign, got.flip, got.sticky} !== {e.pos, e.sign, e.flip, e.sticky}) begin
                        errors++; $display("FAIL bp_order item %0d: got %h/%b%b%b want %h/%b%b%b", delivered,
                                           got.pos, got.sign, got.flip, got.sticky, e.pos, e.sign, e.flip, e.sticky);
                    end
                end
                delivered++;
            end else gap_ok = 0;
            if (in_valid && in_ready) begin exp_q.push_back(model(ops[idx])); idx++; end
        end
        in_valid = 0;
        checks++;
        if (delivered != 4 || !gap_ok) begin
            errors++; $display("FAIL bp_delivery: got %0d delivered gapless=%b want 4 gapless=1", delivered, gap_ok);
        end
    endtask

    task automatic test_flush();
        op_t o; res_t got; res_t e; bit ok; bit seen;
        @(negedge clk);
        out_ready = 0; flush = 0;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            drive(rand_op()); in_valid = 1;
        end
        @(negedge clk);
        drive(rand_op()); in_valid = 1; flush = 1;
        @(negedge clk);
        flush = 0; in_valid = 0; out_ready = 1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (out_valid) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL flush_dropped_input: got out_valid=1 want 0"); end
        o = rand_op();
        e = model(o);
        run_single(o, got, ok);
        checks++;
        if (!ok || got.pos !== e.pos) begin errors++; $display("FAIL flush_recover: got %h want %h", got.pos, e.pos); end
    endtask

    task automatic test_async_reset();
        op_t o; bit seen;
        o = zero_op();
        o.exp_mv = 1; o.a = HW'(5); o.sgn = 1;
        @(negedge clk);
        out_ready = 0; flush = 0;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            drive(o); in_valid = 1;
        end
        @(negedge clk);
        in_valid = 0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b want 1", out_valid); end
        #1;
        rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || pos_sum !== '0) begin
            errors++; $display("FAIL arst_clear: got valid=%b pos=%h want valid=0 pos=0", out_valid, pos_sum);
        end
        @(negedge clk);
        rst_n = 1; out_ready = 1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (out_valid) seen = 1;
        end
        checks++;
        if (seen || in_ready !== 1'b1) begin
            errors++; $display("FAIL arst_after: got out_valid_seen=%b in_ready=%b want 0 1", seen, in_ready);
        end
    endtask

    task automatic test_random();
        res_t q[$];
        res_t got, e;
        op_t  o;
        bit   fl;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            fl = ($urandom_range(0, 29) == 0);
            o = rand_op();
            drive(o);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = fl ? 1'b0 : ($urandom_range(0, 9) < 6);
            flush     = fl;
            #1;
            if (out_valid && out_ready) begin
                sample(got);
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious cycle %0d: got %h want nothing", cyc, got.pos);
                end else begin
                    e = q.pop_front();
                    if ({got.pos, got.sign, got.flip, got.sticky} !== {e.pos, e.sign, e.flip, e.sticky}) begin
                        errors++; $display("FAIL rand_result cycle %0d: got %h/%b%b%b want %h/%b%b%b", cyc,
                                           got.pos, got.sign, got.flip, got.sticky, e.pos, e.sign, e.flip, e.sticky);
                    end
                end
            end
            if (fl) q.delete();
            else if (in_valid && in_ready) q.push_back(model(o));
        end
        @(negedge clk);
        flush = 0; in_valid = 0; out_ready = 1;
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                sample(got);
                e = q.pop_front();
                checks++;
                if ({got.pos, got.sign, got.flip, got.sticky} !== {e.pos, e.sign, e.flip, e.sticky}) begin
                    errors++; $display("FAIL rand_drain: got %h want %h", got.pos, e.pos);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL rand_lost: got %0d pending want 0", q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_exp_mv();
        test_flip_halt();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
